three_cs_src: RTL
=================

Name: three_cs_src

Overview:
- Transmit-side counterpart of the three-instance blockC consumer.
- Accepts one upstream command stream and steers each payload to one of three ready/valid source ports (see0/see1/see2), or broadcasts it to all three.
- Each output has a one-entry registered slot, so a stalled consumer blocks only traffic aimed at it.
- Sits directly upstream of the three-consumer wrapper, driving its see0..see2 inputs.

Parameters:
- DATA_W, 32: payload width carried on each see port.
- CNT_W, 16: width of per-channel statistics counters (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd  rdy_vld_if.dst  DATA_W+2  upstream command; data = {dest[1:0], payload[DATA_W-1:0]}
- see0  rdy_vld_if.src  DATA_W  output channel 0
- see1  rdy_vld_if.src  DATA_W  output channel 1
- see2  rdy_vld_if.src  DATA_W  output channel 2
- busy  output  1  high while any slot holds data
- stat_clr  input  1  synchronous clear of counters (optional feature only)
- cnt0/cnt1/cnt2  output  CNT_W  completed-handshake counts (optional feature only)

Behaviour:
- Per-slot state:
  - Slot N holds vld_q[N] and data_q[N].
  - seeN.vld = vld_q[N] and seeN.data = data_q[N], both directly from flops.
  - There is no combinational path from any rdy to any vld.
- Slot free: free[N] = !vld_q[N] | seeN.rdy, i.e. empty, or draining this cycle.
- cmd.rdy:
  - dest 0..2: equals free[dest].
  - dest 3 (broadcast): equals free[0] & free[1] & free[2].
  - cmd.rdy depends combinationally on seeN.rdy. This path is intended.
- Accept (cmd.vld & cmd.rdy):
  - Load payload into the target slot(s) and set vld_q next cycle.
  - Latency is 1 cycle from accept to seeN.vld.
- Broadcast is atomic: all three slots load in the same cycle, or none do. A broadcast never partially loads.
- After a broadcast loads, the three slots drain independently.
- Drain: seeN.vld & seeN.rdy with no load to N in the same cycle clears vld_q[N].
- Simultaneous drain and load on the same slot: data_q takes the new payload and vld_q stays 1. Full throughput is one transfer per cycle per channel.
- Stability: while vld_q[N]=1 and seeN.rdy=0, data_q[N] holds.
- Ordering: per-channel order equals cmd acceptance order.
- Reset:
  - All vld_q=0, data_q=0, busy=0; counters are 0 when the feature is enabled.
  - Asserting reset mid-operation discards pending slot contents without completing them.
  - First accept is possible the cycle after rst_n deasserts.
- busy = |vld_q, registered-derived (no rdy dependence).
- Idle: cmd.vld=0 means no state change except drains.

Optional Feature:
- Macro THREE_CS_SRC_STATS_EN.
- When defined:
  - stat_clr, cnt0, cnt1, cnt2 exist.
  - cntN increments on each seeN handshake and saturates at all-ones.
  - stat_clr zeroes all counters next cycle; clear wins over a same-cycle increment.
  - Counters are reset to 0 by rst_n.
- When undefined: those ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package three_cs_src_package holds:
  - dest encoding enum: DEST_C0=0, DEST_C1=1, DEST_C2=2, DEST_BCAST=3
  - cmd struct typedef {dest, payload}
  - NUM_CH=3 constant
- Sub-module three_cs_src_slot: one-entry output register with load/drain/free logic and the optional counter. Instanced three times.

Test Plan:
- Reset with cmd.vld=1: no seeN.vld during reset. First accept occurs the cycle after rst_n rises, and see0.vld appears 1 cycle later.
- Unicast streaming: back-to-back dest=1 payloads 0x10..0x13 with see1.rdy=1. see1 shows 0x10..0x13 on consecutive cycles and cmd.rdy stays 1.
- Stalled channel isolation:
  - Setup: see0.rdy=0, slot0 full.
  - dest=0 command: cmd.rdy=0.
  - dest=2 payload 0xAB: accepted, and see2 shows 0xAB next cycle.
- Broadcast atomicity:
  - Setup: see1.rdy=0 with slot1 full, then dest=3 payload 0x55.
  - While stalled: cmd.rdy=0 and slots 0 and 2 unchanged.
  - Release see1.rdy: all three see ports show 0x55 on the same cycle.
- Backpressure stability: see1.rdy low for 5 cycles with data 0xDEAD held. data stays 0xDEAD and vld stays 1. The handshake completes on the rdy cycle, then busy drops.
- With THREE_CS_SRC_STATS_EN, CNT_W=2: 5 handshakes on see0 gives cnt0=3 (saturated). stat_clr pulse gives cnt0=0 next cycle.

Source files
------------

// File: rtl/three_cs_src_pkg.sv
// Shared types for the three-way source steering block: destination codes,
// the upstream command layout and the channel count.
package three_cs_src_package;

    localparam int NUM_CH    = 3;
    localparam int PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        DEST_C0    = 2'd0,
        DEST_C1    = 2'd1,
        DEST_C2    = 2'd2,
        DEST_BCAST = 2'd3
    } dest_e;

    // Upstream command word as seen on cmd.data for the default payload width.
    typedef struct packed {
        dest_e                  dest;
        logic [PAYLOAD_W-1:0]   payload;
    } cmd_t;

endpackage

// File: rtl/three_cs_src_if.sv
// Generic ready/valid channel used for the command input and the three see ports.
interface rdy_vld_if #(parameter int W = 32);

    // A transfer happens on a clock edge where vld & rdy are both high. Once the
    // source raises vld it keeps vld and data stable until that transfer; the
    // sink may drive rdy freely, including as a function of vld.
    logic         vld;
    logic         rdy;
    logic [W-1:0] data;

    modport src (output vld, output data, input rdy);
    modport dst (input vld, input data, output rdy);

endinterface

// File: rtl/three_cs_src_slot.sv
// One-entry registered output slot for a single see port; with
// THREE_CS_SRC_STATS_EN it also counts completed handshakes (saturating).
module three_cs_src_slot #(
    parameter int DATA_W = 32
`ifdef THREE_CS_SRC_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              free,
    rdy_vld_if.src            see
`ifdef THREE_CS_SRC_STATS_EN
    , input  logic             stat_clr
    , output logic [CNT_W-1:0] cnt
`endif
);

    logic              vld_q;
    logic [DATA_W-1:0] data_q;

    assign see.vld  = vld_q;
    assign see.data = data_q;
    assign free     = !vld_q || see.rdy;

    // Load has priority over drain so a same-cycle drain+load keeps vld high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load) begin
            vld_q  <= 1'b1;
            data_q <= load_data;
        end else if (see.rdy) begin
            vld_q  <= 1'b0;
        end
    end

`ifdef THREE_CS_SRC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stat_clr) begin
            cnt <= '0;
        end else if (vld_q && see.rdy && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/three_cs_src.sv
// Steers upstream commands to one of three see ports or broadcasts to all.
// Optional per-channel handshake counters are enabled by THREE_CS_SRC_STATS_EN.
module three_cs_src
    import three_cs_src_package::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    rdy_vld_if.dst cmd,
    rdy_vld_if.src see0,
    rdy_vld_if.src see1,
    rdy_vld_if.src see2,
    output logic   busy
`ifdef THREE_CS_SRC_STATS_EN
    , input  logic             stat_clr
    , output logic [CNT_W-1:0] cnt0
    , output logic [CNT_W-1:0] cnt1
    , output logic [CNT_W-1:0] cnt2
`endif
);

    dest_e             dest;
    logic [DATA_W-1:0] payload;
    logic [NUM_CH-1:0] free;
    logic [NUM_CH-1:0] load;
    logic              cmd_rdy;

    assign dest    = dest_e'(cmd.data[DATA_W+1:DATA_W]);
    assign payload = cmd.data[DATA_W-1:0];

    // Broadcast needs every slot free so the three loads happen together or not at all.
    always_comb begin
        cmd_rdy = 1'b0;
        case (dest)
            DEST_C0:    cmd_rdy = free[0];
            DEST_C1:    cmd_rdy = free[1];
            DEST_C2:    cmd_rdy = free[2];
            DEST_BCAST: cmd_rdy = &free;
            default:    cmd_rdy = 1'b0;
        endcase
    end

    assign cmd.rdy = cmd_rdy;

    always_comb begin
        load = '0;
        if (cmd.vld && cmd_rdy) begin
            case (dest)
                DEST_C0:    load = 3'b001;
                DEST_C1:    load = 3'b010;
                DEST_C2:    load = 3'b100;
                DEST_BCAST: load = 3'b111;
                default:    load = '0;
            endcase
        end
    end

    assign busy = see0.vld || see1.vld || see2.vld;

`ifdef THREE_CS_SRC_STATS_EN
    three_cs_src_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot0 (
        .clk(clk), .rst_n(rst_n), .load(load[0]), .load_data(payload),
        .free(free[0]), .see(see0), .stat_clr(stat_clr), .cnt(cnt0));
    three_cs_src_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot1 (
        .clk(clk), .rst_n(rst_n), .load(load[1]), .load_data(payload),
        .free(free[1]), .see(see1), .stat_clr(stat_clr), .cnt(cnt1));
    three_cs_src_slot #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_slot2 (
        .clk(clk), .rst_n(rst_n), .load(load[2]), .load_data(payload),
        .free(free[2]), .see(see2), .stat_clr(stat_clr), .cnt(cnt2));
`else
    three_cs_src_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk(clk), .rst_n(rst_n), .load(load[0]), .load_data(payload),
        .free(free[0]), .see(see0));
    three_cs_src_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk(clk), .rst_n(rst_n), .load(load[1]), .load_data(payload),
        .free(free[1]), .see(see1));
    three_cs_src_slot #(.DATA_W(DATA_W)) u_slot2 (
        .clk(clk), .rst_n(rst_n), .load(load[2]), .load_data(payload),
        .free(free[2]), .see(see2));
`endif

endmodule
